// File: rtl/ag_vram_pkg.sv
// rtl/ag_vram_pkg.sv - shared types, lane-select width and power-up pattern for the VRAM stream block
package ag_vram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } burst_state_e;

  localparam logic [7:0] INIT_EVEN = 8'hCC;
  localparam logic [7:0] INIT_ODD  = 8'h33;

  function automatic int lane_sel_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 0;
  endfunction

endpackage

// File: rtl/ag_vram_stream_if.sv
// rtl/ag_vram_stream_if.sv - CPU byte port and video burst stream signals of ag_vram_stream
interface ag_vram_stream_if
  import ag_vram_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int WORD_AW = 14,
  parameter int LEN_W   = 8
);
  logic                                 CS1;
  logic                                 READ;
  logic [WORD_AW+lane_sel_w(LANES)-1:0] AB1;
  logic [7:0]                           DI1;
  logic [7:0]                           DO1;
  logic                                 REQ2;
  logic [WORD_AW-1:0]                   AB2;
  logic [LEN_W-1:0]                     LEN2;
  logic [8*LANES-1:0]                   DO2;
  logic                                 VLD2;
  logic                                 ACK2;
  logic                                 BUSY2;

  modport master (
    output CS1, READ, AB1, DI1, REQ2, AB2, LEN2, ACK2,
    input  DO1, DO2, VLD2, BUSY2
  );

  modport slave (
    input  CS1, READ, AB1, DI1, REQ2, AB2, LEN2, ACK2,
    output DO1, DO2, VLD2, BUSY2
  );
endinterface

// File: rtl/ag_vram_fifo.sv
// rtl/ag_vram_fifo.sv - synchronous prefetch FIFO with registered head word and occupancy count
module ag_vram_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         push_tdata_i,
  input  logic                     push_tvalid_i,
  input  logic                     pop_tready_i,
  output logic [WIDTH-1:0]         head_tdata_o,
  output logic                     head_tvalid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push, pop;

  assign pop  = pop_tready_i && (count_q != '0);
  assign push = push_tvalid_i && ((count_q != CW'(DEPTH)) || pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      head_d  = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      // The head register shadows buf_q[rd]; an incoming word lands there directly when it becomes the head.
      if (count_d == '0)                           head_d = '0;
      else if (push && ((count_q - CW'(pop)) == '0)) head_d = push_tdata_i;
      else if (pop)                                head_d = buf_q[rd_q + 1'b1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) buf_q[wr_q] <= push_tdata_i;
  end

  assign head_tdata_o  = head_q;
  assign head_tvalid_o = (count_q != '0);
  assign count_o       = count_q;
endmodule

// File: rtl/ag_vram_stream.sv
// rtl/ag_vram_stream.sv - dual-port VRAM: CPU byte port plus video burst prefetch into a FIFO
// Define AG_VRAM_INIT_PATTEN_EN for a CC/33 (even/odd word) power-up pattern instead of zeros.
module ag_vram_stream
  import ag_vram_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int WORD_AW    = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input logic             CLK,
  input logic             RST,
  ag_vram_stream_if.slave bus
);
  localparam int LSW   = lane_sel_w(LANES);
  localparam int LSW_C = (LSW == 0) ? 1 : LSW;
  localparam int DEPTH = 2 ** WORD_AW;
  localparam int WW    = 8 * LANES;
  localparam int RW    = LEN_W + 1;

`ifdef AG_VRAM_INIT_PATTEN_EN
  localparam logic [7:0] PAT_EVEN = INIT_EVEN;
  localparam logic [7:0] PAT_ODD  = INIT_ODD;
`else
  localparam logic [7:0] PAT_EVEN = 8'h00;
  localparam logic [7:0] PAT_ODD  = 8'h00;
`endif

  function automatic logic [7:0] init_byte(input logic odd);
    return odd ? PAT_ODD : PAT_EVEN;
  endfunction

  // Words are stored XORed with the power-up pattern, so a zero-initialised array reads back as that pattern.
  logic [WW-1:0]      mem_q [DEPTH] = '{default: {WW{1'b0}}};
  logic [WORD_AW-1:0] cpu_word;
  logic [LSW_C-1:0]   cpu_lane;
  logic               cpu_we;
  logic [7:0]         cpu_rd_byte;
  logic [7:0]         do1_q;

  assign cpu_word = bus.AB1[WORD_AW+LSW-1:LSW];
  assign cpu_lane = (LANES == 1) ? '0 : LSW_C'(bus.AB1);
  assign cpu_we   = bus.CS1 && !bus.READ;

  always_comb begin
    cpu_rd_byte = '0;
    for (int l = 0; l < LANES; l++) begin
      if (cpu_lane == LSW_C'(l)) cpu_rd_byte = mem_q[cpu_word][8*l +: 8] ^ init_byte(cpu_word[0]);
    end
  end

  always_ff @(posedge CLK) begin
    for (int l = 0; l < LANES; l++) begin
      if (cpu_we && (cpu_lane == LSW_C'(l))) mem_q[cpu_word][8*l +: 8] <= bus.DI1 ^ init_byte(cpu_word[0]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                          do1_q <= '0;
    else if (bus.CS1 && bus.READ)     do1_q <= cpu_rd_byte;
  end

  burst_state_e       state_q, state_d;
  logic [WORD_AW-1:0] addr_q, addr_d;
  logic [RW-1:0]      remain_q, remain_d;
  logic               rd_vld_q;
  logic [WW-1:0]      vid_data_q;
  logic               issue, flush, room, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic               fifo_vld;
  logic [WW-1:0]      fifo_head;

  // Room counts the read already in flight and credits a pop happening this same cycle.
  assign pop  = bus.ACK2 && fifo_vld;
  assign room = (int'(fifo_cnt) + int'(rd_vld_q)) < (FIFO_DEPTH + int'(pop));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    issue    = 1'b0;
    flush    = 1'b0;
    if (bus.REQ2) begin
      flush    = 1'b1;
      state_d  = ST_FETCH;
      addr_d   = bus.AB2;
      remain_d = (bus.LEN2 == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.LEN2};
    end else if ((state_q == ST_FETCH) && room) begin
      issue    = 1'b1;
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
      if (remain_q == RW'(1)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      rd_vld_q <= issue;
    end
  end

  always_ff @(posedge CLK) begin
    vid_data_q <= mem_q[addr_q] ^ {LANES{init_byte(addr_q[0])}};
  end

  ag_vram_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (CLK),
    .rst_i         (RST),
    .flush_i       (flush),
    .push_tdata_i  (vid_data_q),
    .push_tvalid_i (rd_vld_q),
    .pop_tready_i  (bus.ACK2),
    .head_tdata_o  (fifo_head),
    .head_tvalid_o (fifo_vld),
    .count_o       (fifo_cnt)
  );

  assign bus.DO1   = do1_q;
  assign bus.DO2   = fifo_head;
  assign bus.VLD2  = fifo_vld;
  assign bus.BUSY2 = (state_q == ST_FETCH);
endmodule
